// File: rtl/hazard_pkg.sv
// Shared encodings and the register-match rule for the hazard/scoreboard unit.
package hazard_pkg;

  localparam logic [1:0] FW_RF = 2'd0;
  localparam logic [1:0] FW_M  = 2'd1;
  localparam logic [1:0] FW_W  = 2'd2;

  // Widest register address the match helper accepts; callers zero-extend.
  localparam int MAX_AW = 16;

  typedef enum logic {
    MC_IDLE,
    MC_BUSY
  } mc_state_e;

  function automatic logic reg_match(input logic [MAX_AW-1:0] a,
                                     input logic [MAX_AW-1:0] b,
                                     input logic              en,
                                     input logic              r0_hw);
    return en && (a == b) && !(r0_hw && (a == '0));
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-source EX forward selector: MEM result beats WB result, else register file.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW           = 5,
  parameter bit R0_HARDWIRED = 1'b0
) (
  input  logic [AW-1:0] ra,
  input  logic          used,
  input  logic [AW-1:0] wa_m,
  input  logic          wen_m,
  input  logic [AW-1:0] wa_w,
  input  logic          wen_w,
  output logic [1:0]    fw
);

  logic hit_m;
  logic hit_w;

  always_comb begin
    hit_m = used && reg_match(MAX_AW'(ra), MAX_AW'(wa_m), !wen_m, R0_HARDWIRED);
    hit_w = used && reg_match(MAX_AW'(ra), MAX_AW'(wa_w), !wen_w, R0_HARDWIRED);
    fw    = FW_RF;
    if (hit_m)      fw = FW_M;
    else if (hit_w) fw = FW_W;
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use / forwarding hazard logic with a one-entry multi-cycle op scoreboard.
//   state   | meaning
//   MC_IDLE | mc_cnt == 0, no multi-cycle result outstanding
//   MC_BUSY | mc_cnt  > 0, result for mc_dst pending; write issued when mc_cnt == 1
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int AW           = 5,
  parameter int NSRC         = 2,
  parameter int LOAD_LAT     = 1,
  parameter int MC_LAT       = 8,
  parameter bit R0_HARDWIRED = 1'b0
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NSRC*AW-1:0] RA_D,
  input  logic [NSRC-1:0]    SrcUsed_D,
  input  logic [AW-1:0]      WA_D,
  input  logic               WEN_D,
  input  logic               MCOp_D,
  input  logic [NSRC*AW-1:0] RA_E,
  input  logic [NSRC-1:0]    SrcUsed_E,
  input  logic [AW-1:0]      WA_E,
  input  logic               Load_E,
  input  logic               MCOp_E,
  input  logic [AW-1:0]      WA_M,
  input  logic               WEN_M,
  input  logic [AW-1:0]      WA_W,
  input  logic               WEN_W,
  input  logic               BrFlush,
  output logic               PCWrite,
  output logic               FDWrite,
  output logic               DEFlush,
  output logic [2*NSRC-1:0]  FW,
  output logic               MCBusy,
  output logic               MCWrite,
  output logic [AW-1:0]      MCWA
);

  localparam int MCW = $clog2(MC_LAT + 1);
  localparam int LDW = $clog2(LOAD_LAT + 1);

  logic [MCW-1:0] mc_cnt_q, mc_cnt_d;
  logic [AW-1:0]  mc_dst_q, mc_dst_d;
  logic [LDW-1:0] ld_cnt_q, ld_cnt_d;

  mc_state_e mc_state;
  logic      ld_hit, ld_trig, ld_stall;
  logic      mc_raw, mc_stall, stall;

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    hazard_fwd_sel #(.AW(AW), .R0_HARDWIRED(R0_HARDWIRED)) u_fwd_sel (
      .ra    (RA_E[i*AW +: AW]),
      .used  (SrcUsed_E[i]),
      .wa_m  (WA_M),
      .wen_m (WEN_M),
      .wa_w  (WA_W),
      .wen_w (WEN_W),
      .fw    (FW[2*i +: 2])
    );
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mc_cnt_q <= '0;
      mc_dst_q <= '0;
      ld_cnt_q <= '0;
    end else begin
      mc_cnt_q <= mc_cnt_d;
      mc_dst_q <= mc_dst_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  always_comb begin
    ld_hit = 1'b0;
    mc_raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (reg_match(MAX_AW'(RA_D[i*AW +: AW]), MAX_AW'(WA_E), SrcUsed_D[i], R0_HARDWIRED))
        ld_hit = Load_E;
      if (reg_match(MAX_AW'(RA_D[i*AW +: AW]), MAX_AW'(mc_dst_q), SrcUsed_D[i], R0_HARDWIRED))
        mc_raw = 1'b1;
    end

    mc_state = (mc_cnt_q == '0) ? MC_IDLE : MC_BUSY;
    mc_cnt_d = mc_cnt_q;
    mc_dst_d = mc_dst_q;
    MCBusy   = 1'b0;
    MCWrite  = 1'b0;
    mc_stall = 1'b0;
    case (mc_state)
      MC_IDLE: begin
        if (MCOp_E) begin
          mc_cnt_d = MCW'(MC_LAT);
          mc_dst_d = WA_E;
        end
      end
      MC_BUSY: begin
        MCBusy   = 1'b1;
        mc_cnt_d = mc_cnt_q - MCW'(1);
        MCWrite  = (mc_cnt_q == MCW'(1));
        mc_stall = mc_raw || MCOp_D ||
                   reg_match(MAX_AW'(WA_D), MAX_AW'(mc_dst_q), !WEN_D, R0_HARDWIRED);
      end
      default: ;
    endcase
    MCWA = mc_dst_q;
  end

  always_comb begin
    ld_trig  = ld_hit && (ld_cnt_q == '0);
    ld_stall = ld_trig || (ld_cnt_q != '0);
    ld_cnt_d = ld_cnt_q;
    // A resolved branch kills the stalled D instruction, so any pending load bubble is moot.
    if (BrFlush)                ld_cnt_d = '0;
    else if (ld_cnt_q != '0)    ld_cnt_d = ld_cnt_q - LDW'(1);
    else if (ld_trig)           ld_cnt_d = LDW'(LOAD_LAT - 1);

    stall   = (ld_stall || mc_stall) && !BrFlush;
    PCWrite = !stall;
    FDWrite = !stall;
    DEFlush = stall;
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two parameterisations driven by shared stimulus.
module tb_hazard_scoreboard_unit;

  logic        CLK, RSTN;
  logic [9:0]  RA_D, RA_E;
  logic [1:0]  SrcUsed_D, SrcUsed_E;
  logic [4:0]  WA_D, WA_E, WA_M, WA_W;
  logic        WEN_D, MCOp_D, Load_E, MCOp_E, WEN_M, WEN_W, BrFlush;

  logic        pcw_a, fdw_a, def_a, busy_a, mcw_a;
  logic        pcw_b, fdw_b, def_b, busy_b, mcw_b;
  logic [3:0]  fw_a, fw_b;
  logic [4:0]  mcwa_a, mcwa_b;
  logic [13:0] obs [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [13:0] RST_OBS = 14'b11_0_0000_0_0_00000;

  // Model parameters per instance: [0] = LOAD_LAT 1, MC_LAT 4, R0 live; [1] = 3, 8, R0 hardwired
  int p_ld [2] = '{1, 3};
  int p_mc [2] = '{4, 8};
  bit p_r0 [2] = '{1'b0, 1'b1};

  typedef struct {
    int         ld_until;
    int         mc_start;
    int         mc_end;
    logic [4:0] mc_dst;
  } mstate_t;
  mstate_t ms [2];

  typedef struct {
    logic [9:0] ra_e;
    logic [1:0] used_e;
    logic [4:0] wa_m;
    logic       wen_m;
    logic [4:0] wa_w;
    logic       wen_w;
    logic [3:0] fw_exp;
  } fvec_t;
  fvec_t tbl [6];

  hazard_scoreboard_unit #(.AW(5), .NSRC(2), .LOAD_LAT(1), .MC_LAT(4), .R0_HARDWIRED(1'b0)) dut_a (
    .CLK(CLK), .RSTN(RSTN), .RA_D(RA_D), .SrcUsed_D(SrcUsed_D), .WA_D(WA_D), .WEN_D(WEN_D),
    .MCOp_D(MCOp_D), .RA_E(RA_E), .SrcUsed_E(SrcUsed_E), .WA_E(WA_E), .Load_E(Load_E),
    .MCOp_E(MCOp_E), .WA_M(WA_M), .WEN_M(WEN_M), .WA_W(WA_W), .WEN_W(WEN_W), .BrFlush(BrFlush),
    .PCWrite(pcw_a), .FDWrite(fdw_a), .DEFlush(def_a), .FW(fw_a), .MCBusy(busy_a),
    .MCWrite(mcw_a), .MCWA(mcwa_a));

  hazard_scoreboard_unit #(.AW(5), .NSRC(2), .LOAD_LAT(3), .MC_LAT(8), .R0_HARDWIRED(1'b1)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .RA_D(RA_D), .SrcUsed_D(SrcUsed_D), .WA_D(WA_D), .WEN_D(WEN_D),
    .MCOp_D(MCOp_D), .RA_E(RA_E), .SrcUsed_E(SrcUsed_E), .WA_E(WA_E), .Load_E(Load_E),
    .MCOp_E(MCOp_E), .WA_M(WA_M), .WEN_M(WEN_M), .WA_W(WA_W), .WEN_W(WEN_W), .BrFlush(BrFlush),
    .PCWrite(pcw_b), .FDWrite(fdw_b), .DEFlush(def_b), .FW(fw_b), .MCBusy(busy_b),
    .MCWrite(mcw_b), .MCWA(mcwa_b));

  assign obs[0] = {pcw_a, fdw_a, def_a, fw_a, busy_a, mcw_a, mcwa_a};
  assign obs[1] = {pcw_b, fdw_b, def_b, fw_b, busy_b, mcw_b, mcwa_b};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model: absolute-cycle windows ----------------
  function automatic logic m_match(input logic [4:0] a, input logic [4:0] b, input logic en, input bit r0);
    return en && (a == b) && !(r0 && a == 5'd0);
  endfunction

  function automatic logic m_ldhit(input int k);
    logic h = 1'b0;
    for (int i = 0; i < 2; i++)
      if (m_match(RA_D[i*5 +: 5], WA_E, SrcUsed_D[i], p_r0[k])) h = 1'b1;
    return h && Load_E;
  endfunction

  function automatic logic m_busy(input int k);
    return (cyc > ms[k].mc_start) && (cyc <= ms[k].mc_end);
  endfunction

  function automatic logic [13:0] model_out(input int k);
    logic [3:0] fw;
    logic       busy, mcst, stall;
    fw   = 4'd0;
    mcst = 1'b0;
    busy = m_busy(k);
    for (int i = 0; i < 2; i++) begin
      if (SrcUsed_E[i]) begin
        if (m_match(RA_E[i*5 +: 5], WA_M, !WEN_M, p_r0[k]))      fw[2*i +: 2] = 2'd1;
        else if (m_match(RA_E[i*5 +: 5], WA_W, !WEN_W, p_r0[k])) fw[2*i +: 2] = 2'd2;
      end
      if (busy && m_match(RA_D[i*5 +: 5], ms[k].mc_dst, SrcUsed_D[i], p_r0[k])) mcst = 1'b1;
    end
    if (busy && (MCOp_D || m_match(WA_D, ms[k].mc_dst, !WEN_D, p_r0[k]))) mcst = 1'b1;
    stall = ((cyc <= ms[k].ld_until) || m_ldhit(k) || mcst) && !BrFlush;
    return {!stall, !stall, stall, fw, busy, busy && (cyc == ms[k].mc_end), ms[k].mc_dst};
  endfunction

  task automatic model_update(input int k);
    logic free = (cyc > ms[k].ld_until);
    if (BrFlush)                  ms[k].ld_until = cyc;
    else if (free && m_ldhit(k))  ms[k].ld_until = cyc + p_ld[k] - 1;
    if (!m_busy(k) && MCOp_E) begin
      ms[k].mc_start = cyc;
      ms[k].mc_end   = cyc + p_mc[k];
      ms[k].mc_dst   = WA_E;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k].ld_until = -1;
      ms[k].mc_start = 0;
      ms[k].mc_end   = -1;
      ms[k].mc_dst   = 5'd0;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic step(input string name, input int sa = -1, input int sb = -1,
                      input int fwa = -1, input int fwb = -1, input int busya = -1,
                      input int mcwa = -1, input int wa = -1);
    logic [13:0] e, a;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      e = model_out(k);
      a = obs[k];
      if (!e[5]) begin
        e[4:0] = 5'd0;
        a[4:0] = 5'd0;
      end
      chk($sformatf("%s/model%0d", name, k), a, e);
    end
    if (sa >= 0)    chk({name, "/stall_a"}, {11'd0, obs[0][13:11]}, (sa != 0) ? 14'b001 : 14'b110);
    if (sb >= 0)    chk({name, "/stall_b"}, {11'd0, obs[1][13:11]}, (sb != 0) ? 14'b001 : 14'b110);
    if (fwa >= 0)   chk({name, "/fw_a"}, {10'd0, obs[0][10:7]}, 14'(fwa));
    if (fwb >= 0)   chk({name, "/fw_b"}, {10'd0, obs[1][10:7]}, 14'(fwb));
    if (busya >= 0) chk({name, "/busy_a"}, {13'd0, obs[0][6]}, 14'(busya));
    if (mcwa >= 0)  chk({name, "/mcwrite_a"}, {13'd0, obs[0][5]}, 14'(mcwa));
    if (wa >= 0)    chk({name, "/mcwa_a"}, {9'd0, obs[0][4:0]}, 14'(wa));
    @(posedge CLK);
    model_update(0);
    model_update(1);
    cyc++;
    #1;
  endtask

  task automatic idle();
    RA_D = '0; SrcUsed_D = '0; WA_D = '0; WEN_D = 1'b1; MCOp_D = 1'b0;
    RA_E = '0; SrcUsed_E = '0; WA_E = '0; Load_E = 1'b0; MCOp_E = 1'b0;
    WA_M = '0; WEN_M = 1'b1; WA_W = '0; WEN_W = 1'b1; BrFlush = 1'b0;
  endtask

  initial begin
    tbl[0] = '{{5'd7, 5'd0}, 2'b10, 5'd7, 1'b0, 5'd7, 1'b0, 4'b0100};
    tbl[1] = '{{5'd7, 5'd0}, 2'b10, 5'd7, 1'b1, 5'd7, 1'b0, 4'b1000};
    tbl[2] = '{{5'd7, 5'd0}, 2'b00, 5'd7, 1'b0, 5'd7, 1'b0, 4'b0000};
    tbl[3] = '{{5'd7, 5'd3}, 2'b11, 5'd3, 1'b0, 5'd7, 1'b0, 4'b1001};
    tbl[4] = '{{5'd0, 5'd0}, 2'b11, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0101};
    tbl[5] = '{{5'd0, 5'd4}, 2'b01, 5'd5, 1'b0, 5'd4, 1'b1, 4'b0000};

    idle();
    model_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_a", obs[0], RST_OBS);
    chk("reset_b", obs[1], RST_OBS);
    RSTN = 1'b1;

    // Forwarding table
    for (int t = 0; t < 6; t++) begin
      RA_E = tbl[t].ra_e; SrcUsed_E = tbl[t].used_e;
      WA_M = tbl[t].wa_m; WEN_M = tbl[t].wen_m;
      WA_W = tbl[t].wa_w; WEN_W = tbl[t].wen_w;
      step($sformatf("fwd_tbl%0d", t), 0, 0, int'(tbl[t].fw_exp));
    end
    idle();

    // Load-use: single bubble on A, three on B
    Load_E = 1'b1; WA_E = 5'd5; RA_D = {5'd0, 5'd5}; SrcUsed_D = 2'b01;
    step("ld_trig", 1, 1);
    Load_E = 1'b0;
    step("ld_s2", 0, 1);
    step("ld_s3", 0, 1);
    step("ld_done", 0, 0);

    // Load-use with branch flush in the second stall cycle
    Load_E = 1'b1;
    step("ldbr_trig", 1, 1);
    Load_E = 1'b0; BrFlush = 1'b1;
    step("ldbr_flush", 0, 0);
    BrFlush = 1'b0;
    step("ldbr_after", 0, 0);
    idle();

    // r0 hazard: live on A, hardwired on B
    Load_E = 1'b1; WA_E = 5'd0; RA_D = '0; SrcUsed_D = 2'b01;
    RA_E = '0; SrcUsed_E = 2'b01; WA_M = 5'd0; WEN_M = 1'b0;
    step("r0_ld", 1, 0, 1, 0);
    idle();
    step("r0_clear", 0, 0);

    // Multi-cycle scoreboard: RAW, WAW, structural, unrelated
    for (int kind = 0; kind < 4; kind++) begin
      MCOp_E = 1'b1; WA_E = 5'd9;
      step($sformatf("mc%0d_issue", kind), 0, -1, -1, -1, 0, 0);
      MCOp_E = 1'b0; WA_E = 5'd0;
      case (kind)
        0: begin RA_D = {5'd0, 5'd9}; SrcUsed_D = 2'b01; end
        1: begin WA_D = 5'd9; WEN_D = 1'b0; end
        2: MCOp_D = 1'b1;
        default: begin RA_D = {5'd3, 5'd0}; SrcUsed_D = 2'b10; WA_D = 5'd3; WEN_D = 1'b0; end
      endcase
      for (int j = 1; j <= 5; j++)
        step($sformatf("mc%0d_c%0d", kind, j), (kind != 3 && j <= 4) ? 1 : 0, -1, -1, -1,
             (j <= 4) ? 1 : 0, (j == 4) ? 1 : 0, (j == 4) ? 9 : -1);
      idle();
      repeat (4) step("mc_drain");
    end

    // Reset in the middle of a multi-cycle op
    MCOp_E = 1'b1; WA_E = 5'd9;
    step("rst_issue");
    idle();
    step("rst_c4", -1, -1, -1, -1, 1, 0);
    step("rst_c3", -1, -1, -1, -1, 1, 0);
    RSTN = 1'b0;
    #1;
    chk("midrst_a", obs[0], RST_OBS);
    chk("midrst_b", obs[1], RST_OBS);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    repeat (8) step("post_rst", 0, 0, -1, -1, 0, 0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      RA_D      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      SrcUsed_D = 2'($urandom_range(0, 3));
      WA_D      = 5'($urandom_range(0, 3));
      WEN_D     = 1'($urandom_range(0, 1));
      MCOp_D    = ($urandom_range(0, 7) == 0);
      RA_E      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      SrcUsed_E = 2'($urandom_range(0, 3));
      WA_E      = 5'($urandom_range(0, 3));
      Load_E    = ($urandom_range(0, 3) == 0);
      MCOp_E    = !m_busy(0) && !m_busy(1) && ($urandom_range(0, 9) == 0);
      WA_M      = 5'($urandom_range(0, 3));
      WEN_M     = 1'($urandom_range(0, 1));
      WA_W      = 5'($urandom_range(0, 3));
      WEN_W     = 1'($urandom_range(0, 1));
      BrFlush   = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
